// File: rtl/sd_spi_cmd_host.sv
// SPI-mode SD command engine: sends a 48-bit command frame, then collects an R1/R7 response.
// Define SD_CMD_CRC_EN to compute CRC7 with a serial LFSR; without it the CRC comes from a fixed table.
module sd_spi_cmd_host #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NCR_MAX    = 8,
    parameter int unsigned TRAIL_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_long,
    output logic        busy,
    output logic        done,
    output logic        resp_timeout,
    output logic [39:0] resp_data,
    output logic        SD_CLK,
    output logic        SD_CS,
    output logic        SD_OUT,
    input  logic        SD_IN
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, TRAIL} state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [46:0] frame;
    logic [38:0] shift;
    logic [15:0] cnt;
    logic        long_q;
    logic        tick, rise, fall;
    logic [6:0]  crc;
    logic [47:0] next_frame;

`ifdef SD_CMD_CRC_EN
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = bits[39 - i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    always_comb crc = crc7({2'b01, cmd_index, cmd_arg});
`else
    always_comb begin
        case (cmd_index)
            6'd0:    crc = 7'h4A;
            6'd8:    crc = 7'h43;
            default: crc = 7'h7F;
        endcase
    end
`endif

    always_comb begin
        next_frame = {2'b01, cmd_index, cmd_arg, crc, 1'b1};
        tick       = (state != IDLE) && (div_cnt == 8'(CLK_DIV - 1));
        rise       = tick && !SD_CLK;
        fall       = tick && SD_CLK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            resp_timeout <= 1'b0;
            resp_data    <= '0;
            SD_CLK       <= 1'b0;
            SD_CS        <= 1'b1;
            SD_OUT       <= 1'b1;
            div_cnt      <= '0;
            frame        <= '0;
            shift        <= '0;
            cnt          <= '0;
            long_q       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                    SD_CLK  <= ~SD_CLK;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
            case (state)
                IDLE: begin
                    // busy is still 1 in the done cycle, so a start there is dropped
                    busy <= 1'b0;
                    if (cmd_start && !busy) begin
                        frame        <= next_frame[46:0];
                        SD_OUT       <= next_frame[47];
                        long_q       <= resp_long;
                        resp_timeout <= 1'b0;
                        busy         <= 1'b1;
                        SD_CS        <= 1'b0;
                        cnt          <= '0;
                        div_cnt      <= '0;
                        shift        <= '0;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (fall) begin
                        if (cnt == 16'd47) begin
                            SD_OUT <= 1'b1;
                            cnt    <= '0;
                            state  <= WAIT_RESP;
                        end else begin
                            SD_OUT <= frame[46];
                            frame  <= frame << 1;
                            cnt    <= cnt + 16'd1;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (rise) begin
                        if (!SD_IN) begin
                            // start bit is 0, so the cleared shifter already holds it
                            cnt   <= long_q ? 16'd39 : 16'd7;
                            state <= RECV;
                        end else if (cnt == 16'(NCR_MAX * 8 - 1)) begin
                            resp_timeout <= 1'b1;
                            resp_data    <= '1;
                            SD_CS        <= 1'b1;
                            cnt          <= '0;
                            state        <= TRAIL;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                RECV: begin
                    if (rise) begin
                        shift <= {shift[37:0], SD_IN};
                        if (cnt == 16'd1) begin
                            resp_data <= {shift, SD_IN};
                            SD_CS     <= 1'b1;
                            cnt       <= '0;
                            state     <= TRAIL;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                TRAIL: begin
                    if (rise) begin
                        cnt <= cnt + 16'd1;
                    end else if (fall && cnt == 16'(TRAIL_CLKS)) begin
                        done    <= 1'b1;
                        SD_CLK  <= 1'b0;
                        div_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_host.sv
// Self-checking bench for sd_spi_cmd_host with a bit-level SD card model and a frame/response reference model.
module tb_sd_spi_cmd_host;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned NCR_MAX    = 8;
    localparam int unsigned TRAIL_CLKS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_long;
    logic        busy, done, resp_timeout;
    logic [39:0] resp_data;
    logic        SD_CLK, SD_CS, SD_OUT;
    logic        SD_IN = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic mosi_bits[$];
    logic card_bits[$];

    sd_spi_cmd_host #(
        .CLK_DIV   (CLK_DIV),
        .NCR_MAX   (NCR_MAX),
        .TRAIL_CLKS(TRAIL_CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_long   (resp_long),
        .busy        (busy),
        .done        (done),
        .resp_timeout(resp_timeout),
        .resp_data   (resp_data),
        .SD_CLK      (SD_CLK),
        .SD_CS       (SD_CS),
        .SD_OUT      (SD_OUT),
        .SD_IN       (SD_IN)
    );

    always #5 clk = ~clk;

    always @(posedge SD_CLK) if (!SD_CS) mosi_bits.push_back(SD_OUT);

    // Card drives on its falling edge once the 48-bit command has been clocked in.
    always @(negedge SD_CLK) begin
        if (!SD_CS && mosi_bits.size() >= 48 && card_bits.size() > 0) SD_IN = card_bits.pop_front();
        else SD_IN = 1'b1;
    end

    always @(negedge clk) if (done) done_cnt++;

    // CRC7 as polynomial long division of message*x^7 by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [6:0] c;
`ifdef SD_CMD_CRC_EN
        c = ref_crc({2'b01, idx, arg});
`else
        c = (idx == 6'd0) ? 7'h4A : (idx == 6'd8) ? 7'h43 : 7'h7F;
`endif
        return {2'b01, idx, arg, c, 1'b1};
    endfunction

    function automatic int ref_lat(input logic lng, input int unsigned w);
        int unsigned sd;
        if (w >= NCR_MAX) sd = 48 + 8 * NCR_MAX + TRAIL_CLKS;
        else sd = 48 + 8 * w + (lng ? 40 : 8) + TRAIL_CLKS;
        return int'(sd * 2 * CLK_DIV);
    endfunction

    function automatic logic [39:0] ref_resp(input logic lng, input int unsigned w, input logic [39:0] rsp);
        if (w >= NCR_MAX) return '1;
        return lng ? rsp : {32'b0, rsp[7:0]};
    endfunction

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                           input int unsigned wbytes, input logic [39:0] rsp, input bit poke,
                           output logic [47:0] fr, output logic [39:0] rd, output logic tmo,
                           output int lat, output logic cs_at_done, output int ndone,
                           output logic busy_after);
        int n;
        int d0;
        bit got;
        mosi_bits.delete();
        card_bits.delete();
        for (int i = 0; i < int'(8 * wbytes); i++) card_bits.push_back(1'b1);
        for (int i = 0; i < (lng ? 40 : 8); i++) card_bits.push_back(rsp[(lng ? 39 : 7) - i]);
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_long = lng; cmd_start = 1'b1;
        d0 = done_cnt; n = 0; got = 0;
        rd = '0; tmo = 1'b0; cs_at_done = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (n == 1) cmd_start = 1'b0;
            if (poke && n == 60) begin cmd_start = 1'b1; cmd_index = 6'h3F; cmd_arg = '1; end
            if (poke && n == 61) cmd_start = 1'b0;
            if (done) begin
                got = 1; rd = resp_data; tmo = resp_timeout; cs_at_done = SD_CS;
                if (poke) cmd_start = 1'b1;
            end
        end
        lat = got ? n - 1 : -1;
        @(negedge clk);
        cmd_start = 1'b0;
        @(negedge clk);
        busy_after = busy;
        repeat (8) @(negedge clk);
        ndone = done_cnt - d0;
        fr = '0;
        for (int i = 0; i < 48; i++) if (i < mosi_bits.size()) fr[47 - i] = mosi_bits[i];
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_long = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (resp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got=%b exp=0", resp_timeout); end
        n_cmp++; if (resp_data !== 40'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", resp_data); end
        n_cmp++; if ({SD_CLK, SD_CS, SD_OUT} !== 3'b011) begin n_fail++; $display("FAIL reset_pins got=%b exp=011", {SD_CLK, SD_CS, SD_OUT}); end
    endtask

    task automatic test_known_frames;
        logic [47:0] fr; logic [39:0] rd; logic tmo, cs, ba; int lat, nd;
        run_cmd(6'd0, 32'h0, 1'b0, 1, 40'h01, 0, fr, rd, tmo, lat, cs, nd, ba);
        n_cmp++; if (fr !== 48'h40_0000_0000_95) begin n_fail++; $display("FAIL cmd0_frame got=%h exp=400000000095", fr); end
        n_cmp++; if (rd !== 40'h01) begin n_fail++; $display("FAIL cmd0_resp got=%h exp=01", rd); end
        n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL cmd0_tmo got=%b exp=0", tmo); end
        n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL cmd0_dones got=%0d exp=1", nd); end
        n_cmp++; if (lat < 576 || lat > 578) begin n_fail++; $display("FAIL cmd0_latency got=%0d exp=576..578", lat); end
        run_cmd(6'd8, 32'h1AA, 1'b1, 1, 40'h01_0000_01AA, 0, fr, rd, tmo, lat, cs, nd, ba);
        n_cmp++; if (fr !== 48'h48_0000_01AA_87) begin n_fail++; $display("FAIL cmd8_frame got=%h exp=48000001aa87", fr); end
        n_cmp++; if (rd !== 40'h01_0000_01AA) begin n_fail++; $display("FAIL cmd8_resp got=%h exp=01000001aa", rd); end
        n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL cmd8_tmo got=%b exp=0", tmo); end
        run_cmd(6'd41, 32'h4000_0000, 1'b0, 0, 40'h00, 0, fr, rd, tmo, lat, cs, nd, ba);
`ifdef SD_CMD_CRC_EN
        n_cmp++; if (fr[7:0] !== {ref_crc({2'b01, 6'd41, 32'h4000_0000}), 1'b1}) begin n_fail++; $display("FAIL acmd41_crc got=%h", fr[7:0]); end
`else
        n_cmp++; if (fr[7:0] !== 8'hFF) begin n_fail++; $display("FAIL acmd41_crc got=%h exp=ff", fr[7:0]); end
`endif
        n_cmp++; if (rd !== 40'h00) begin n_fail++; $display("FAIL acmd41_resp got=%h exp=00", rd); end
    endtask

    task automatic test_timeout;
        logic [47:0] fr; logic [39:0] rd; logic tmo, cs, ba; int lat, nd;
        run_cmd(6'd17, 32'h1234_5678, 1'b0, NCR_MAX, 40'hFF_FFFF_FFFF, 0, fr, rd, tmo, lat, cs, nd, ba);
        n_cmp++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got=%b exp=1", tmo); end
        n_cmp++; if (rd !== 40'hFF_FFFF_FFFF) begin n_fail++; $display("FAIL tmo_data got=%h exp=ffffffffff", rd); end
        n_cmp++; if (cs !== 1'b1) begin n_fail++; $display("FAIL tmo_cs_at_done got=%b exp=1", cs); end
        n_cmp++; if (lat < 960 || lat > 962) begin n_fail++; $display("FAIL tmo_latency got=%0d exp=960..962", lat); end
    endtask

    task automatic test_ignore_start;
        logic [47:0] fr; logic [39:0] rd; logic tmo, cs, ba; int lat, nd;
        run_cmd(6'd16, 32'h0000_0200, 1'b0, 2, 40'h05, 1, fr, rd, tmo, lat, cs, nd, ba);
        n_cmp++; if (fr !== ref_frame(6'd16, 32'h200)) begin n_fail++; $display("FAIL ignore_frame got=%h exp=%h", fr, ref_frame(6'd16, 32'h200)); end
        n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_dones got=%0d exp=1", nd); end
        n_cmp++; if (ba !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after got=%b exp=0", ba); end
        n_cmp++; if (rd !== 40'h05) begin n_fail++; $display("FAIL ignore_resp got=%h exp=05", rd); end
    endtask

    task automatic test_reset_mid;
        logic [47:0] fr; logic [39:0] rd; logic tmo, cs, ba; int lat, nd, d0, n;
        mosi_bits.delete(); card_bits.delete();
        @(negedge clk);
        cmd_index = 6'd17; cmd_arg = $urandom; resp_long = 1'b0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        n = 0;
        while (mosi_bits.size() < 21 && n < 2000) begin @(negedge clk); n++; end
        n_cmp++; if (n >= 2000) begin n_fail++; $display("FAIL rstmid_reach_bit20 got=%0d bits exp=21", mosi_bits.size()); end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({SD_CS, SD_OUT, SD_CLK, busy, done} !== 5'b11000) begin n_fail++; $display("FAIL rstmid_pins got=%b exp=11000", {SD_CS, SD_OUT, SD_CLK, busy, done}); end
        repeat (700) @(negedge clk);
        n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, d0); end
        run_cmd(6'd55, 32'h0, 1'b0, 1, 40'h01, 0, fr, rd, tmo, lat, cs, nd, ba);
`ifdef SD_CMD_CRC_EN
        n_cmp++; if (fr !== 48'h77_0000_0000_65) begin n_fail++; $display("FAIL cmd55_frame got=%h exp=770000000065", fr); end
`else
        n_cmp++; if (fr !== 48'h77_0000_0000_FF) begin n_fail++; $display("FAIL cmd55_frame got=%h exp=7700000000ff", fr); end
`endif
        n_cmp++; if (rd !== 40'h01 || nd !== 1) begin n_fail++; $display("FAIL cmd55_resp got=%h/%0d exp=01/1", rd, nd); end
    endtask

    task automatic test_random;
        logic [47:0] fr; logic [39:0] rd, rsp; logic tmo, cs, ba, lng; int lat, nd;
        logic [5:0] idx; logic [31:0] arg; int unsigned w;
        for (int t = 0; t < 14; t++) begin
            idx = 6'($urandom); arg = $urandom; lng = 1'($urandom);
            w = $urandom_range(0, 9);
            rsp = {8'($urandom), 32'($urandom)};
            if (lng) rsp[39] = 1'b0; else rsp[7] = 1'b0;
            run_cmd(idx, arg, lng, w, rsp, 0, fr, rd, tmo, lat, cs, nd, ba);
            n_cmp++; if (fr !== ref_frame(idx, arg)) begin n_fail++; $display("FAIL rnd%0d_frame got=%h exp=%h", t, fr, ref_frame(idx, arg)); end
            n_cmp++; if (rd !== ref_resp(lng, w, rsp)) begin n_fail++; $display("FAIL rnd%0d_resp got=%h exp=%h", t, rd, ref_resp(lng, w, rsp)); end
            n_cmp++; if (tmo !== (w >= NCR_MAX)) begin n_fail++; $display("FAIL rnd%0d_tmo got=%b exp=%b", t, tmo, w >= NCR_MAX); end
            n_cmp++; if (lat < ref_lat(lng, w) || lat > ref_lat(lng, w) + 2) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, lat, ref_lat(lng, w)); end
            n_cmp++; if (nd !== 1 || cs !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done got=%0d/cs%b exp=1/cs1", t, nd, cs); end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_long = 1'b0;
        test_reset;
        test_known_frames;
        test_timeout;
        test_ignore_start;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
